// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED pattern engine: pattern mode encodings,
// bounce direction encodings and a generic bit-reverse helper.
// No ports (package).
// -----------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [1:0] {
    LED_MODE_BOUNCE = 2'd0,
    LED_MODE_ROTATE = 2'd1,
    LED_MODE_FILL   = 2'd2,
    LED_MODE_HOLD   = 2'd3
  } led_mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Reverse the low w bits of v (w <= 32); bits at and above w return 0.
  function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i[4:0]] = v[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_engine_if.sv
// -----------------------------------------------------------------------------
// led_pattern_engine_if
// Groups the pattern engine's control inputs and LED/status outputs.
//   i_mode  [1:0]           pattern select (bounce/rotate/fill/hold)
//   i_div   [DIVBITS-1:0]   step period minus one, in clock cycles
//   o_led   [NLEDS-1:0]     registered PWM LED drive
//   o_pos   [$clog2(NLEDS)] index of highest set bit of the owner mask
//   o_step                  one-cycle strobe per pattern step
// master: board status logic side; slave: the engine.
// -----------------------------------------------------------------------------
interface led_pattern_engine_if #(
  parameter int NLEDS   = 8,
  parameter int DIVBITS = 24
);
  localparam int POSW = $clog2(NLEDS);

  logic [1:0]         i_mode;
  logic [DIVBITS-1:0] i_div;
  logic [NLEDS-1:0]   o_led;
  logic [POSW-1:0]    o_pos;
  logic               o_step;

  modport master (output i_mode, i_div, input o_led, o_pos, o_step);
  modport slave  (input i_mode, i_div, output o_led, o_pos, o_step);

endinterface

// File: rtl/led_pwm_chan.sv
// -----------------------------------------------------------------------------
// led_pwm_chan
// One LED channel: brightness register with load-on-own / halve-on-step
// decay, optional gamma stage, and registered PWM compare output.
//   i_clk, i_reset  clock, asynchronous active-high reset
//   i_step          pattern step strobe (brightness updates only here)
//   i_own           this LED is in the owner mask
//   i_cmp [NPWM]    bit-reversed PWM counter shared by all channels
//   o_led           registered LED drive
// Optional build macro: LED_PATTERN_GAMMA_EN (squares the duty, adds one
// register stage so o_led latency becomes 2 cycles).
// -----------------------------------------------------------------------------
module led_pwm_chan #(
  parameter int NPWM = 9
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_step,
  input  logic            i_own,
  input  logic [NPWM-1:0] i_cmp,
  output logic            o_led
);

  logic [NPWM-1:0] bright_q, bright_d;
  logic            led_q, led_d;

  always_comb begin
    bright_d = bright_q;
    if (i_step) bright_d = i_own ? '1 : (bright_q >> 1);
  end

`ifdef LED_PATTERN_GAMMA_EN
  logic [2*NPWM-1:0] sq;
  logic [NPWM-1:0]   duty;
  logic [NPWM-1:0]   duty_p1, cmp_p1;
  logic              full_p1, zero_p1;

  always_comb begin
    sq    = (2*NPWM)'(bright_q) * (2*NPWM)'(bright_q);
    duty  = NPWM'(sq >> NPWM);
    led_d = full_p1 | (~zero_p1 & (cmp_p1 < duty_p1));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bright_q <= '0;
      duty_p1  <= '0;
      cmp_p1   <= '0;
      full_p1  <= 1'b0;
      zero_p1  <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      bright_q <= bright_d;
      // stage p1: gamma-corrected duty and end-point flags
      duty_p1  <= duty;
      cmp_p1   <= i_cmp;
      full_p1  <= &bright_q;
      zero_p1  <= ~|bright_q;
      // stage p2: compare to LED pin
      led_q    <= led_d;
    end
  end
`else
  always_comb begin
    // All-ones must force on: the compare alone would miss cmp == all-ones.
    led_d = (&bright_q) | ((|bright_q) & (i_cmp < bright_q));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bright_q <= '0;
      led_q    <= 1'b0;
    end else begin
      bright_q <= bright_d;
      led_q    <= led_d;
    end
  end
`endif

  assign o_led = led_q;

endmodule

// File: rtl/led_pattern_engine.sv
// -----------------------------------------------------------------------------
// led_pattern_engine
// Multi-mode LED pattern generator (bounce, rotate, fill, hold) with a runtime
// step divider and per-LED PWM fade tails.
//   i_clk    system clock
//   i_reset  asynchronous active-high reset
//   bus      led_pattern_engine_if.slave: i_mode, i_div in; o_led, o_pos,
//            o_step out (all outputs registered)
// Holds the step timer, mode register, owner mask/direction and PWM counter;
// each LED's brightness and compare live in an led_pwm_chan instance.
// Optional build macro: LED_PATTERN_GAMMA_EN (handled in led_pwm_chan).
// -----------------------------------------------------------------------------
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int NLEDS   = 8,
  parameter int NPWM    = 9,
  parameter int DIVBITS = 24
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  led_pattern_engine_if.slave   bus
);

  localparam int POSW = $clog2(NLEDS);

  logic [DIVBITS-1:0] div_ctr_q, div_ctr_d;
  led_mode_e          mode_q, mode_d, mode_req;
  logic [NLEDS-1:0]   owner_q, owner_d;
  logic               dir_q, dir_d;
  logic [NPWM-1:0]    pwm_ctr_q, pwm_ctr_d;
  logic [NPWM-1:0]    cmp;
  logic [POSW-1:0]    pos_q, pos_d;
  logic               step_q;
  logic               step;
  logic [NLEDS-1:0]   led_w;

  function automatic logic [POSW-1:0] top_index(input logic [NLEDS-1:0] m);
    logic [POSW-1:0] r;
    r = '0;
    for (int k = 0; k < NLEDS; k++) begin
      if (m[k]) r = POSW'(k);
    end
    return r;
  endfunction

  assign mode_req = led_mode_e'(bus.i_mode);

  always_comb begin
    // >= rather than == so lowering i_div below the count steps at once.
    step      = (div_ctr_q >= bus.i_div);
    div_ctr_d = step ? '0 : (div_ctr_q + DIVBITS'(1));
    pwm_ctr_d = pwm_ctr_q + NPWM'(1);
    cmp       = NPWM'(bit_reverse(32'(pwm_ctr_q), NPWM));
    pos_d     = top_index(owner_q);
  end

  always_comb begin
    mode_d  = mode_q;
    owner_d = owner_q;
    dir_d   = dir_q;
    if (step) mode_d = mode_req;

    if (owner_q == '0) begin
      owner_d = NLEDS'(1);
      dir_d   = DIR_UP;
    end else if (step) begin
      if (mode_req != mode_q) begin
        // Mode switch restarts the pattern instead of advancing it.
        owner_d = NLEDS'(1);
        dir_d   = DIR_UP;
      end else begin
        case (mode_q)
          LED_MODE_BOUNCE: begin
            // Reversing at an end holds the owner for one step (end pause).
            if (dir_q == DIR_UP) begin
              if (owner_q[NLEDS-1]) dir_d = DIR_DOWN;
              else                  owner_d = owner_q << 1;
            end else begin
              if (owner_q[0]) dir_d = DIR_UP;
              else            owner_d = owner_q >> 1;
            end
          end
          LED_MODE_ROTATE: owner_d = {owner_q[NLEDS-2:0], owner_q[NLEDS-1]};
          LED_MODE_FILL:   owner_d = (&owner_q) ? NLEDS'(1) : {owner_q[NLEDS-2:0], 1'b1};
          LED_MODE_HOLD:   owner_d = owner_q;
          default:         owner_d = owner_q;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div_ctr_q <= '0;
      mode_q    <= LED_MODE_BOUNCE;
      owner_q   <= NLEDS'(1);
      dir_q     <= DIR_UP;
      pwm_ctr_q <= '0;
      pos_q     <= '0;
      step_q    <= 1'b0;
    end else begin
      div_ctr_q <= div_ctr_d;
      mode_q    <= mode_d;
      owner_q   <= owner_d;
      dir_q     <= dir_d;
      pwm_ctr_q <= pwm_ctr_d;
      pos_q     <= pos_d;
      step_q    <= step;
    end
  end

  // Brightness reacts to the owner mask as it stood before this step.
  for (genvar k = 0; k < NLEDS; k++) begin : g_chan
    led_pwm_chan #(.NPWM(NPWM)) u_chan (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_step  (step),
      .i_own   (owner_q[k]),
      .i_cmp   (cmp),
      .o_led   (led_w[k])
    );
  end

  assign bus.o_led  = led_w;
  assign bus.o_pos  = pos_q;
  assign bus.o_step = step_q;

endmodule
